// File: rtl/mc_core.sv
`timescale 1ns/1ps
// Purpose: multi-cycle 9-bit-ISA core with 8 registers, a carry flag, a sync ROM port and a ready-handshaked data port; MC_CORE_PERF_EN adds the perf counters.
// Latency: ALU/LDI/BNZ/HALT take 3 cycles (FETCH, DECODE, EXEC); LD/ST take 2+N cycles, N = MEM cycles up to dm_ready.
// Backpressure: dm_re/dm_we stay high in MEM with stable addr/data until dm_ready; the core stalls in MEM meanwhile.
module mc_core #(
    parameter int DW    = 8,
    parameter int PW    = 10,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             start_n,
    output logic [PW-1:0]    inst_addr,
    input  logic [8:0]       inst_data,
    output logic [DW-1:0]    dm_addr,
    output logic [DW-1:0]    dm_wdata,
    output logic             dm_re,
    output logic             dm_we,
    input  logic [DW-1:0]    dm_rdata,
    input  logic             dm_ready,
    output logic             halt,
    output logic [CNT_W-1:0] cycle_ct,
    output logic [CNT_W-1:0] instr_ct
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_ST  = 3'b011;
    localparam logic [2:0] OP_LSL = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_LD  = 3'b110;
    localparam logic [2:0] OP_BNZ = 3'b111;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED} state_t;

    state_t          state, state_nxt;
    logic [8:0]      ir;
    logic [PW-1:0]   pc;
    logic [DW-1:0]   regs [8];
    logic            carry;

    logic [2:0]      op, rd_idx, rs_idx;
    logic [DW-1:0]   rd_val, rs_val;
    logic            is_halt;
    logic [PW-1:0]   pc_inc;

    logic            exec_en, mem_done;
    logic [DW:0]     sum;
    logic [DW-1:0]   alu_res;
    logic            alu_c, wr_en, c_en;

    assign op        = ir[8:6];
    assign rd_idx    = ir[5:3];
    assign rs_idx    = ir[2:0];
    assign rd_val    = regs[rd_idx];
    assign rs_val    = regs[rs_idx];
    assign is_halt   = (ir == 9'h1FF);
    assign pc_inc    = pc + PW'(1);
    assign inst_addr = pc;
    assign dm_addr   = rs_val;
    assign dm_wdata  = rd_val;

    always_ff @(posedge CLK or negedge start_n) begin
        if (!start_n) state <= S_FETCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        dm_re     = 1'b0;
        dm_we     = 1'b0;
        exec_en   = 1'b0;
        mem_done  = 1'b0;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = (inst_data[8:6] == OP_ST || inst_data[8:6] == OP_LD) ? S_MEM : S_EXEC;
            S_EXEC: begin
                exec_en   = 1'b1;
                state_nxt = is_halt ? S_HALTED : S_FETCH;
            end
            S_MEM: begin
                dm_re = (op == OP_LD);
                dm_we = (op == OP_ST);
                if (dm_ready) begin
                    mem_done  = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // SUB adds the complement so the carry-out reads as "no borrow"
    always_comb begin
        sum     = '0;
        alu_res = rd_val;
        alu_c   = carry;
        wr_en   = 1'b0;
        c_en    = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, rd_val} + {1'b0, rs_val};
                alu_res = sum[DW-1:0]; alu_c = sum[DW]; wr_en = 1'b1; c_en = 1'b1;
            end
            OP_ADC: begin
                sum = {1'b0, rd_val} + {1'b0, rs_val} + (DW+1)'(carry);
                alu_res = sum[DW-1:0]; alu_c = sum[DW]; wr_en = 1'b1; c_en = 1'b1;
            end
            OP_SUB: begin
                sum = {1'b0, rd_val} + {1'b0, ~rs_val} + (DW+1)'(1);
                alu_res = sum[DW-1:0]; alu_c = sum[DW]; wr_en = 1'b1; c_en = 1'b1;
            end
            OP_LSL: begin
                alu_res = {rd_val[DW-2:0], carry}; alu_c = rd_val[DW-1]; wr_en = 1'b1; c_en = 1'b1;
            end
            OP_LDI: begin
                alu_res = DW'(rs_idx); wr_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge start_n) begin
        if (!start_n) begin
            pc    <= '0;
            ir    <= '0;
            carry <= 1'b0;
            halt  <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            if (state == S_DECODE) ir <= inst_data;
            if (exec_en) begin
                if (is_halt) begin
                    halt <= 1'b1;
                end else if (op == OP_BNZ) begin
                    pc <= (rd_val != '0) ? PW'(rs_val) : pc_inc;
                end else begin
                    pc <= pc_inc;
                    if (wr_en) regs[rd_idx] <= alu_res;
                    if (c_en)  carry <= alu_c;
                end
            end
            if (mem_done) begin
                pc <= pc_inc;
                if (op == OP_LD) regs[rd_idx] <= dm_rdata;
            end
        end
    end

`ifdef MC_CORE_PERF_EN
    logic [CNT_W-1:0] cyc_q, ins_q;
    logic             retire;

    assign retire = exec_en | mem_done;

    always_ff @(posedge CLK or negedge start_n) begin
        if (!start_n) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (!halt && cyc_q != '1)  cyc_q <= cyc_q + CNT_W'(1);
            if (retire && ins_q != '1) ins_q <= ins_q + CNT_W'(1);
        end
    end

    assign cycle_ct = cyc_q;
    assign instr_ct = ins_q;
`else
    assign cycle_ct = '0;
    assign instr_ct = '0;
`endif

endmodule
